// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: drives one row at a time, debounces a single pressed
// key and reports it as a one-cycle strobe, then tracks hold and release.
//
// state    | meaning
// ---------+----------------------------------------------------------
// SCAN     | rows rotate every SCAN_DIV cycles, columns sampled at wrap
// DEBOUNCE | row frozen, waiting for DEBOUNCE_CNT matching samples
// HELD     | key accepted and still pressed
// RELEASE  | all columns low, waiting for DEBOUNCE_CNT clean cycles
module keypad_scanner #(
  parameter int SCAN_DIV     = 16,
  parameter int DEBOUNCE_CNT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic [1:0] state_out
);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);
  localparam logic [15:0] DB_LAST   = 16'(DEBOUNCE_CNT - 1);

  state_t      state;
  logic [1:0]  row_idx;
  logic [1:0]  col_idx;
  logic [15:0] presc;
  logic [15:0] db_cnt;
  logic [3:0]  col_meta;
  logic [3:0]  col_s;
  logic        col_onehot;
  logic [1:0]  col_enc;
  logic [3:0]  col_mask;

  // Two-flop synchronizer; the raw column lines are never used elsewhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta <= 4'b0000;
      col_s    <= 4'b0000;
    end else begin
      col_meta <= col_in;
      col_s    <= col_meta;
    end
  end

  // Single-key detection and column encoding of the synchronized sample.
  always_comb begin
    col_onehot = 1'b0;
    col_enc    = 2'd0;
    case (col_s)
      4'b0001: begin col_onehot = 1'b1; col_enc = 2'd0; end
      4'b0010: begin col_onehot = 1'b1; col_enc = 2'd1; end
      4'b0100: begin col_onehot = 1'b1; col_enc = 2'd2; end
      4'b1000: begin col_onehot = 1'b1; col_enc = 2'd3; end
      default: begin col_onehot = 1'b0; col_enc = 2'd0; end
    endcase
    col_mask = 4'b0001 << col_idx;
  end

  // Scan / debounce / hold / release sequencing with registered key outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_SCAN;
      row_idx   <= 2'd0;
      col_idx   <= 2'd0;
      presc     <= 16'd0;
      db_cnt    <= 16'd0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        ST_SCAN: begin
          if (presc == SCAN_LAST) begin
            presc <= 16'd0;
            if (col_onehot) begin
              col_idx <= col_enc;
              db_cnt  <= 16'd0;
              state   <= ST_DEBOUNCE;
            end else begin
              row_idx <= row_idx + 2'd1;
            end
          end else begin
            presc <= presc + 16'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (col_s == col_mask) begin
            if (db_cnt == DB_LAST) begin
              key_code  <= {row_idx, col_idx};
              key_valid <= 1'b1;
              state     <= ST_HELD;
            end else begin
              db_cnt <= db_cnt + 16'd1;
            end
          end else begin
            // Bounce: resume scanning on the same row from a fresh period.
            presc <= 16'd0;
            state <= ST_SCAN;
          end
        end
        ST_HELD: begin
          if (col_s == 4'b0000) begin
            db_cnt <= 16'd0;
            state  <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (col_s != 4'b0000) begin
            state <= ST_HELD;
          end else if (db_cnt == DB_LAST) begin
            presc   <= 16'd0;
            row_idx <= row_idx + 2'd1;
            state   <= ST_SCAN;
          end else begin
            db_cnt <= db_cnt + 16'd1;
          end
        end
        default: state <= ST_SCAN;
      endcase
    end
  end

  assign row_out   = 4'b0001 << row_idx;
  assign key_held  = (state == ST_HELD) || (state == ST_RELEASE);
  assign state_out = state;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_CNT=8). Expected
// key codes are queued by the stimulus and consumed by a key_valid monitor.
module tb_keypad_scanner;

  logic       clk;
  logic       rst_n;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic [1:0] state_out;

  int vectors;
  int miscompares;
  logic [3:0] exp_q[$];
  logic prev_kv;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .col_in(col_in),
    .row_out(row_out),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_held(key_held),
    .state_out(state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_row(input logic [3:0] target);
    for (int k = 0; k < 40 && row_out !== target; k++) step();
    check("wait_row", row_out, target);
  endtask

  // Scoreboard monitor: every key_valid pulse must match the next queued code.
  always @(negedge clk) begin
    if (rst_n) begin
      if (key_valid) begin
        check("kv_back_to_back", {3'b000, prev_kv}, 4'd0);
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_key_valid at %0t: got code %0h expected no strobe", $time, key_code);
        end else begin
          check("key_code", key_code, exp_q.pop_front());
        end
      end
      prev_kv = key_valid;
    end else begin
      prev_kv = 1'b0;
    end
  end

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] er;
    logic [1:0] es;
    vectors     = 0;
    miscompares = 0;
    prev_kv     = 1'b0;
    rst_n       = 1'b0;
    col_in      = 4'b0000;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_row", row_out, 4'b0001);
    check("rst_code", key_code, 4'd0);
    check("rst_valid", {3'b000, key_valid}, 4'd0);
    check("rst_held", {3'b000, key_held}, 4'd0);
    check("rst_state", {2'b00, state_out}, 4'd0);
    rst_n = 1'b1;

    // Idle scan: 4 cycles per row, two full rotations
    for (int i = 0; i < 32; i++) begin
      er = 4'b0001 << ((i / 4) % 4);
      check("idle_row", row_out, er);
      check("idle_state", {2'b00, state_out}, 4'd0);
      step();
    end

    // Key at row 2, col 2 -> code 10, valid 12 cycles after the press appears
    wait_row(4'b0100);
    exp_q.push_back(4'd10);
    col_in = 4'b0100;
    for (int t = 1; t <= 20; t++) begin
      step();
      check("k10_row", row_out, 4'b0100);
      check("k10_valid", {3'b000, key_valid}, (t == 12) ? 4'd1 : 4'd0);
      check("k10_held", {3'b000, key_held}, (t >= 12) ? 4'd1 : 4'd0);
    end
    check("k10_state", {2'b00, state_out}, 4'd2);

    // Release with a two-cycle bounce back to the key
    col_in = 4'b0000;
    for (int t = 1; t <= 17; t++) begin
      if (t - 1 == 4) col_in = 4'b0100;
      if (t - 1 == 6) col_in = 4'b0000;
      step();
      es = (t <= 2) ? 2'd2 : (t <= 6) ? 2'd3 : (t <= 8) ? 2'd2 : (t <= 16) ? 2'd3 : 2'd0;
      check("rel_state", {2'b00, state_out}, {2'b00, es});
      check("rel_held", {3'b000, key_held}, (t <= 16) ? 4'd1 : 4'd0);
      check("rel_row", row_out, (t <= 16) ? 4'b0100 : 4'b1000);
    end

    // Bounce during debounce at row 1, col 1: no key accepted
    wait_row(4'b0010);
    col_in = 4'b0010;
    for (int t = 1; t <= 12; t++) begin
      if (t - 1 == 5) col_in = 4'b0000;
      step();
      es = (t <= 3) ? 2'd0 : (t <= 7) ? 2'd1 : 2'd0;
      check("bnc_state", {2'b00, state_out}, {2'b00, es});
      check("bnc_row", row_out, (t <= 11) ? 4'b0010 : 4'b0100);
      check("bnc_held", {3'b000, key_held}, 4'd0);
    end
    check("bnc_code_kept", key_code, 4'd10);

    // Two columns on row 0: ignored, scanning moves on
    wait_row(4'b0001);
    col_in = 4'b0011;
    for (int t = 1; t <= 8; t++) begin
      step();
      er = (t < 4) ? 4'b0001 : (t < 8) ? 4'b0010 : 4'b0100;
      check("multi_row", row_out, er);
      check("multi_state", {2'b00, state_out}, 4'd0);
    end
    col_in = 4'b0000;

    // Key at row 1, col 0 -> code 4, then clean release advances to row 2
    wait_row(4'b0010);
    exp_q.push_back(4'd4);
    col_in = 4'b0001;
    for (int k = 0; k < 30 && key_held !== 1'b1; k++) step();
    check("k4_held", {3'b000, key_held}, 4'd1);
    check("k4_code", key_code, 4'd4);
    col_in = 4'b0000;
    for (int k = 0; k < 30 && state_out !== 2'd0; k++) step();
    check("k4_scan", {2'b00, state_out}, 4'd0);
    check("k4_row_next", row_out, 4'b0100);

    // Reset in the middle of debounce at row 3
    wait_row(4'b1000);
    col_in = 4'b1000;
    for (int t = 1; t <= 6; t++) begin
      step();
      check("pre_rst_state", {2'b00, state_out}, (t >= 4) ? 4'd1 : 4'd0);
    end
    rst_n = 1'b0;
    #1;
    check("arst_row", row_out, 4'b0001);
    check("arst_state", {2'b00, state_out}, 4'd0);
    check("arst_valid", {3'b000, key_valid}, 4'd0);
    check("arst_held", {3'b000, key_held}, 4'd0);
    check("arst_code", key_code, 4'd0);
    col_in = 4'b0000;
    repeat (3) step();
    check("in_rst_row", row_out, 4'b0001);
    rst_n = 1'b1;
    for (int t = 0; t < 12; t++) begin
      er = (t < 4) ? 4'b0001 : (t < 8) ? 4'b0010 : 4'b0100;
      check("post_rst_row", row_out, er);
      check("post_rst_valid", {3'b000, key_valid}, 4'd0);
      step();
    end

    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL missing_key_valid: got %0d pending codes expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 16, meaning clock cycles each keypad row is driven (legal range 4..65535).
REQ-002 The block SHALL have parameter DEBOUNCE_CNT, default 8, meaning consecutive stable cycles required for press and release (legal range 2..65535).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port col_in, input, 4 bits: keypad column lines, active-high, asynchronous to clk.
REQ-006 The block SHALL have port row_out, output, 4 bits: one-hot keypad row drive, active-high.
REQ-007 The block SHALL have port key_code, output, 4 bits: code of the last accepted key, equal to row_index*4 + col_index.
REQ-008 The block SHALL have port key_valid, output, 1 bit: one-cycle strobe marking a newly accepted key.
REQ-009 The block SHALL have port key_held, output, 1 bit: high while an accepted key remains pressed.
REQ-010 The block SHALL have port state_out, output, 2 bits: FSM state code (SCAN=0, DEBOUNCE=1, HELD=2, RELEASE=3).

Function
REQ-011 col_in SHALL pass through a 2-flop synchronizer; all logic SHALL use only the synchronized value (col_s).
REQ-012 In SCAN, a prescaler SHALL count 0..SCAN_DIV-1; at SCAN_DIV-1 it SHALL wrap to 0 and the row index SHALL advance 0->1->2->3->0.
REQ-013 row_out SHALL equal 1 << row_index in every state.
REQ-014 In SCAN, col_s SHALL be sampled only in the prescaler-terminal cycle, before the row advances.
REQ-015 At that sample, exactly one bit of col_s high SHALL capture the row and column indices, zero the debounce counter, freeze the row and enter DEBOUNCE.
REQ-016 At that sample, zero or two-or-more col_s bits high SHALL leave the FSM in SCAN and advance the row normally.
REQ-017 In DEBOUNCE, each cycle col_s equals the captured one-hot column SHALL increment the debounce counter.
REQ-018 In DEBOUNCE, any cycle col_s differs from the captured column SHALL return the FSM to SCAN with prescaler 0 and the same row, and SHALL not assert key_valid.
REQ-019 When the debounce counter reaches DEBOUNCE_CNT-1 with a match, the next edge SHALL load key_code, pulse key_valid for exactly one cycle and enter HELD.
REQ-020 key_valid SHALL therefore be high exactly DEBOUNCE_CNT cycles after the DEBOUNCE entry edge.
REQ-021 key_held SHALL be high in HELD and RELEASE and low in SCAN and DEBOUNCE.
REQ-022 In HELD, col_s == 0 SHALL zero the debounce counter and enter RELEASE; any nonzero col_s, including extra keys, SHALL stay in HELD with no new key_valid.
REQ-023 In RELEASE, nonzero col_s SHALL return the FSM to HELD.
REQ-024 In RELEASE, DEBOUNCE_CNT consecutive zero cycles SHALL enter SCAN with prescaler 0 and row index advanced by one, wrapping 3->0.
REQ-025 key_code SHALL hold its value until the next accepted key, including through reset deassertion.
REQ-026 key_valid SHALL never be high on two consecutive cycles.

Reset
REQ-027 While rst_n=0: state SCAN, row_out=4'b0001, key_code=0, key_valid=0, key_held=0, state_out=0; prescaler, debounce counter and synchronizer flops SHALL be 0.
REQ-028 Reset asserted in any state, including during DEBOUNCE or RELEASE, SHALL take effect immediately without a clock edge and SHALL suppress any pending key_valid.
REQ-029 After rst_n rises, scanning SHALL start on the first clock edge from row 0, prescaler 0.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=8)
REQ-030 The bench SHALL cover: no keys for 32 cycles -> row_out cycles 0001,0010,0100,1000 at 4 cycles each; key_valid stays 0.
REQ-031 The bench SHALL cover: col_in=4'b0100 held while row 2 is driven -> row frozen at 0100; key_valid pulses once with key_code=10; key_held=1.
REQ-032 The bench SHALL cover: col_in=4'b0010 on row 1 dropping to 0 after 3 DEBOUNCE cycles -> return to SCAN, no key_valid, key_code unchanged.
REQ-033 The bench SHALL cover: key 10 accepted then col_in released with a 2-cycle 0100 bounce -> RELEASE->HELD->RELEASE; key_held falls only after 8 clean zero cycles; row_out then 1000.
REQ-034 The bench SHALL cover: col_in=4'b0011 while row 0 is driven -> no capture; scanning continues to row 1.
REQ-035 The bench SHALL cover: rst_n pulsed low mid-DEBOUNCE -> outputs reset immediately; no key_valid; scan restarts at row_out=0001.
